// File: rtl/ram_port_arbiter.sv
// Two-requester front end for a dual-port RAM with one write and one registered read port.
// Each port arbitrates with its own round-robin pointer; same-cycle write->read is forwarded.
module ram_port_arbiter #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          r0_valid_i,
  input  logic          r0_we_i,
  input  logic [AW-1:0] r0_addr_i,
  input  logic [DW-1:0] r0_wdata_i,
  output logic          r0_ready_o,
  output logic          r0_rvalid_o,
  output logic [DW-1:0] r0_rdata_o,

  input  logic          r1_valid_i,
  input  logic          r1_we_i,
  input  logic [AW-1:0] r1_addr_i,
  input  logic [DW-1:0] r1_wdata_i,
  output logic          r1_ready_o,
  output logic          r1_rvalid_o,
  output logic [DW-1:0] r1_rdata_o,

  output logic          ram_we_o,
  output logic [AW-1:0] ram_write_address_o,
  output logic [DW-1:0] ram_data_in_o,
  output logic [AW-1:0] ram_read_address_o,
  input  logic [DW-1:0] ram_data_out_i
);

  // Arbitration pointers: 0 favours r0, 1 favours r1
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;

  // Read response pipeline
  logic          rd_pend_q, rd_pend_d;
  logic          rd_id_q, rd_id_d;
  logic          byp_q, byp_d;
  logic [DW-1:0] byp_data_q, byp_data_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;

  logic          wr_req0, wr_req1, rd_req0, rd_req1;
  logic          wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;
  logic          wr_gnt, rd_gnt;
  logic [AW-1:0] rd_win_addr;
  logic [DW-1:0] rsp_data;

  // Request decode; reset suppresses every grant
  always_comb begin
    wr_req0 = r0_valid_i &  r0_we_i & ~rst_i;
    wr_req1 = r1_valid_i &  r1_we_i & ~rst_i;
    rd_req0 = r0_valid_i & ~r0_we_i & ~rst_i;
    rd_req1 = r1_valid_i & ~r1_we_i & ~rst_i;
  end

  always_comb begin
    wr_gnt0 = wr_req0 & (~wr_req1 | ~wr_ptr_q);
    wr_gnt1 = wr_req1 & (~wr_req0 |  wr_ptr_q);
    rd_gnt0 = rd_req0 & (~rd_req1 | ~rd_ptr_q);
    rd_gnt1 = rd_req1 & (~rd_req0 |  rd_ptr_q);
    wr_gnt  = wr_gnt0 | wr_gnt1;
    rd_gnt  = rd_gnt0 | rd_gnt1;

    r0_ready_o = wr_gnt0 | rd_gnt0;
    r1_ready_o = wr_gnt1 | rd_gnt1;
  end

  // Pointers move only when both requesters contend for the same port
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_req0 && wr_req1) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (rd_req0 && rd_req1) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  // RAM write port
  always_comb begin
    ram_we_o            = wr_gnt;
    ram_write_address_o = '0;
    ram_data_in_o       = '0;
    if (wr_gnt0) begin
      ram_write_address_o = r0_addr_i;
      ram_data_in_o       = r0_wdata_i;
    end else if (wr_gnt1) begin
      ram_write_address_o = r1_addr_i;
      ram_data_in_o       = r1_wdata_i;
    end
  end

  // RAM read port: address presented in the accept cycle, held when idle
  always_comb begin
    rd_win_addr        = rd_gnt1 ? r1_addr_i : r0_addr_i;
    rd_addr_d          = rd_gnt ? rd_win_addr : rd_addr_q;
    ram_read_address_o = rd_addr_d;
  end

  always_comb begin
    rd_pend_d  = rd_gnt;
    rd_id_d    = rd_id_q;
    byp_d      = byp_q;
    byp_data_d = byp_data_q;
    if (rd_gnt) begin
      rd_id_d    = rd_gnt1;
      // The RAM returns the old word on a same-cycle collision, so capture the new one
      byp_d      = wr_gnt && (ram_write_address_o == rd_win_addr);
      byp_data_d = ram_data_in_o;
    end
  end

  always_comb begin
    rsp_data    = byp_q ? byp_data_q : ram_data_out_i;
    r0_rvalid_o = rd_pend_q & ~rd_id_q & ~rst_i;
    r1_rvalid_o = rd_pend_q &  rd_id_q & ~rst_i;
    r0_rdata_o  = r0_rvalid_o ? rsp_data : '0;
    r1_rdata_o  = r1_rvalid_o ? rsp_data : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_id_q    <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_pend_q  <= rd_pend_d;
      rd_id_q    <= rd_id_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural registered-read RAM.
// Read responses are checked by a scoreboard monitor decoupled from the stimulus.
module tb_ram_port_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  logic          clk;
  logic          rst;
  logic          r0_valid, r0_we, r1_valid, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_ready, r1_ready, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_write_address, ram_read_address;
  logic [DW-1:0] ram_data_in, ram_data_out;

  logic [DW-1:0] mem [256];

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  ram_port_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .r0_valid_i          (r0_valid),
    .r0_we_i             (r0_we),
    .r0_addr_i           (r0_addr),
    .r0_wdata_i          (r0_wdata),
    .r0_ready_o          (r0_ready),
    .r0_rvalid_o         (r0_rvalid),
    .r0_rdata_o          (r0_rdata),
    .r1_valid_i          (r1_valid),
    .r1_we_i             (r1_we),
    .r1_addr_i           (r1_addr),
    .r1_wdata_i          (r1_wdata),
    .r1_ready_o          (r1_ready),
    .r1_rvalid_o         (r1_rvalid),
    .r1_rdata_o          (r1_rdata),
    .ram_we_o            (ram_we),
    .ram_write_address_o (ram_write_address),
    .ram_data_in_o       (ram_data_in),
    .ram_read_address_o  (ram_read_address),
    .ram_data_out_i      (ram_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: read-before-write on a same-address collision
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    ram_data_out = '0;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_write_address] <= ram_data_in;
    ram_data_out <= mem[ram_read_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest expected one; idle rdata must be 0
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (r0_rvalid === 1'b1 || r1_rvalid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", {30'd0, r1_rvalid, r0_rvalid}, e.id ? 32'd2 : 32'd1);
          check("rsp_data", e.id ? {16'd0, r1_rdata} : {16'd0, r0_rdata}, {16'd0, e.data});
        end
      end
      if (r0_rvalid !== 1'b1) check("r0_rdata_idle", {16'd0, r0_rdata}, 32'd0);
      if (r1_rvalid !== 1'b1) check("r1_rdata_idle", {16'd0, r1_rdata}, 32'd0);
    end
  end

  task automatic drive(input logic v0, input logic we0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic v1, input logic we1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
  endtask

  task automatic push(input logic id, input logic [DW-1:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  // One cycle: check grants and RAM port outputs mid-cycle, then advance past the edge
  task automatic run_cycle(input string name, input logic e_rdy0, input logic e_rdy1,
                           input logic e_we, input logic [AW-1:0] e_waddr,
                           input logic [DW-1:0] e_wdata, input int e_raddr);
    @(negedge clk);
    check({name, ".r0_ready"}, {31'd0, r0_ready}, {31'd0, e_rdy0});
    check({name, ".r1_ready"}, {31'd0, r1_ready}, {31'd0, e_rdy1});
    check({name, ".ram_we"}, {31'd0, ram_we}, {31'd0, e_we});
    check({name, ".waddr"}, {24'd0, ram_write_address}, {24'd0, e_waddr});
    check({name, ".wdata"}, {16'd0, ram_data_in}, {16'd0, e_wdata});
    if (e_raddr >= 0) check({name, ".raddr"}, {24'd0, ram_read_address}, e_raddr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1, 1, 8'h55, 16'h1234, 1, 0, 8'h66, 16'h0);
    run_cycle("rst1", 0, 0, 0, 0, 0, -1);
    run_cycle("rst2", 0, 0, 0, 0, 0, -1);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("post_rst", 0, 0, 0, 0, 0, 0);

    // Contested writes: r0 first after reset, then r1, then alternate
    drive(1, 1, 8'h00, 16'h000A, 1, 1, 8'h01, 16'h000B);
    run_cycle("t2a", 1, 0, 1, 8'h00, 16'h000A, -1);
    drive(0, 0, 0, 0, 1, 1, 8'h01, 16'h000B);
    run_cycle("t2b", 0, 1, 1, 8'h01, 16'h000B, -1);
    drive(1, 1, 8'h20, 16'h1111, 1, 1, 8'h21, 16'h2222);
    run_cycle("t2c", 0, 1, 1, 8'h21, 16'h2222, -1);
    drive(1, 1, 8'h22, 16'h3333, 1, 1, 8'h23, 16'h4444);
    run_cycle("t2d", 1, 0, 1, 8'h22, 16'h3333, -1);
    drive(0, 0, 0, 0, 1, 1, 8'h23, 16'h4444);
    run_cycle("t2e", 0, 1, 1, 8'h23, 16'h4444, -1);

    // Read and write from different requesters in one cycle
    drive(1, 0, 8'h00, 16'h0, 1, 1, 8'h02, 16'h000C);
    push(1'b0, 16'h000A);
    run_cycle("t3", 1, 1, 1, 8'h02, 16'h000C, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("t3_idle", 0, 0, 0, 0, 0, 0);
    check("t3.ram2", {16'd0, mem[2]}, 32'h000C);

    // Same-cycle same-address write then read: forwarded new value
    drive(1, 1, 8'h03, 16'h00C0, 1, 0, 8'h03, 16'h0);
    push(1'b1, 16'h00C0);
    run_cycle("t4", 1, 1, 1, 8'h03, 16'h00C0, 3);

    // Contested reads alternate
    drive(1, 0, 8'h00, 16'h0, 1, 0, 8'h01, 16'h0);
    push(1'b0, 16'h000A);
    run_cycle("t5a", 1, 0, 0, 0, 0, 0);
    push(1'b1, 16'h000B);
    run_cycle("t5b", 0, 1, 0, 0, 0, 1);
    push(1'b0, 16'h000A);
    run_cycle("t5c", 1, 0, 0, 0, 0, 0);
    push(1'b1, 16'h000B);
    run_cycle("t5d", 0, 1, 0, 0, 0, 1);

    // Back-to-back reads by one requester
    drive(1, 0, 8'h02, 16'h0, 0, 0, 0, 0);
    push(1'b0, 16'h000C);
    run_cycle("t5e", 1, 0, 0, 0, 0, 2);
    drive(1, 0, 8'h03, 16'h0, 0, 0, 0, 0);
    push(1'b0, 16'h00C0);
    run_cycle("t5f", 1, 0, 0, 0, 0, 3);

    // Reset right after a read is accepted drops the response
    drive(0, 0, 0, 0, 1, 0, 8'h01, 16'h0);
    run_cycle("t6acc", 0, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    run_cycle("t6rst", 0, 0, 0, 0, 0, -1);
    rst = 1'b0;
    run_cycle("t6post", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 8'h01, 16'h0);
    push(1'b1, 16'h000B);
    run_cycle("t6reread", 0, 1, 0, 0, 0, 1);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("drain1", 0, 0, 0, 0, 0, 1);
    run_cycle("drain2", 0, 0, 0, 0, 0, 1);
    check("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
